// File: rtl/controle_acesso_pkg.sv
// Shared definitions for the safe access sequencer: FSM state codes and
// small decode helpers used by the top level.
package controle_acesso_pkg;

    localparam int ST_W = 3;

    localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [ST_W-1:0] ST_ENTRY   = 3'd1;
    localparam logic [ST_W-1:0] ST_CHECK   = 3'd2;
    localparam logic [ST_W-1:0] ST_OPEN    = 3'd3;
    localparam logic [ST_W-1:0] ST_LOCKOUT = 3'd4;
    localparam logic [ST_W-1:0] ST_PROGRAM = 3'd5;

    // The bolt stays retracted both in OPEN and while a new password is keyed in
    function automatic logic lock_released(input logic [ST_W-1:0] st);
        return (st == ST_OPEN) || (st == ST_PROGRAM);
    endfunction

endpackage

// File: rtl/controle_acesso_sec_timer.sv
// One-second prescaler feeding an 8-bit seconds down counter. A load restarts
// the prescaler so the first second after a load is always a full one.
module controle_acesso_sec_timer #(
    parameter int TICK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       run,
    output logic       tick,
    output logic [7:0] sec_left,
    output logic       zero
);

    localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_r;
    logic [7:0]    sec_r;

    assign tick     = run && !load && (pre_r == PRE_LAST);
    assign sec_left = sec_r;
    assign zero     = (sec_r == 8'd0);

    // Prescaler and seconds counter; load beats run
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_r <= '0;
            sec_r <= 8'd0;
        end else if (load) begin
            pre_r <= '0;
            sec_r <= load_val;
        end else if (run) begin
            if (pre_r == PRE_LAST) begin
                pre_r <= '0;
                if (sec_r != 8'd0) begin
                    sec_r <= sec_r - 8'd1;
                end
            end else begin
                pre_r <= pre_r + PW'(1);
            end
        end
    end

endmodule

// File: rtl/controle_acesso.sv
// Safe access sequencer: collects a keyed code, checks it against the stored
// password, drives unlock/relock, wrong-try lockout and password reprogramming.
module controle_acesso
    import controle_acesso_pkg::*;
#(
    parameter int                    DIGITS       = 4,
    parameter logic [DIGITS*4-1:0]   DEFAULT_CODE = 16'h1234,
    parameter int                    MAX_TRIES    = 3,
    parameter int                    TICK_DIV     = 50000000,
    parameter int                    LOCK_SEC     = 30,
    parameter int                    RELOCK_SEC   = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      digit,
    input  logic            enter,
    input  logic            clear,
    input  logic            door_closed,
    input  logic            prog_en,
    input  logic            emerg,
    output logic            unlock,
    output logic            locked_out,
    output logic            err,
    output logic            prog_done,
    output logic [2:0]      tries_left,
    output logic [3:0]      n_digits,
    output logic [7:0]      sec_left,
    output logic [ST_W-1:0] state
);

    localparam int         CW        = DIGITS * 4;
    localparam logic [3:0] DIG_LAST  = 4'(DIGITS);
    localparam logic [2:0] TRIES_MAX = 3'(MAX_TRIES);
    localparam logic [7:0] LOCK_V    = 8'(LOCK_SEC);
    localparam logic [7:0] RELOCK_V  = 8'(RELOCK_SEC);

    logic [ST_W-1:0] state_r, state_nx;
    logic [CW-1:0]   buf_r, buf_nx;
    logic [CW-1:0]   code_r, code_nx;
    logic [3:0]      n_r, n_nx;
    logic [2:0]      tries_r, tries_nx;
    logic            unlock_r, locked_out_r, err_r, prog_done_r;
    logic            err_nx, prog_done_nx;

    logic [CW-1:0]   shifted_s;
    logic [3:0]      n_inc_s;
    logic            last_dig_s;
    logic            tmr_load_s, tmr_run_s, tmr_tick_s, tmr_zero_s;
    logic [7:0]      tmr_val_s, tmr_sec_s;

    // New digit lands in the LSBs so the first digit ends up in the MSBs
    assign shifted_s  = (buf_r << 4) | CW'(digit);
    assign n_inc_s    = n_r + 4'd1;
    assign last_dig_s = (n_inc_s == DIG_LAST);

    controle_acesso_sec_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_sec_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .run      (tmr_run_s),
        .tick     (tmr_tick_s),
        .sec_left (tmr_sec_s),
        .zero     (tmr_zero_s)
    );

    // Next-state, datapath and timer control; emergency overrides everything
    always_comb begin
        state_nx     = state_r;
        buf_nx       = buf_r;
        code_nx      = code_r;
        n_nx         = n_r;
        tries_nx     = tries_r;
        err_nx       = 1'b0;
        prog_done_nx = 1'b0;
        tmr_load_s   = 1'b0;
        tmr_val_s    = RELOCK_V;
        tmr_run_s    = 1'b0;
        if (emerg) begin
            state_nx   = ST_OPEN;
            buf_nx     = '0;
            n_nx       = 4'd0;
            tries_nx   = TRIES_MAX;
            tmr_load_s = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE, ST_ENTRY: begin
                    if (clear) begin
                        buf_nx   = '0;
                        n_nx     = 4'd0;
                        state_nx = ST_IDLE;
                    end else if (enter) begin
                        buf_nx   = shifted_s;
                        n_nx     = n_inc_s;
                        state_nx = last_dig_s ? ST_CHECK : ST_ENTRY;
                    end else begin
                        state_nx = state_r;
                    end
                end
                ST_CHECK: begin
                    buf_nx = '0;
                    n_nx   = 4'd0;
                    if (buf_r == code_r) begin
                        state_nx   = ST_OPEN;
                        tries_nx   = TRIES_MAX;
                        tmr_load_s = 1'b1;
                    end else if (tries_r <= 3'd1) begin
                        err_nx     = 1'b1;
                        tries_nx   = 3'd0;
                        state_nx   = ST_LOCKOUT;
                        tmr_load_s = 1'b1;
                        tmr_val_s  = LOCK_V;
                    end else begin
                        err_nx   = 1'b1;
                        tries_nx = tries_r - 3'd1;
                        state_nx = ST_IDLE;
                    end
                end
                ST_OPEN: begin
                    if (prog_en && enter) begin
                        if (last_dig_s) begin
                            code_nx      = shifted_s;
                            prog_done_nx = 1'b1;
                            tmr_load_s   = 1'b1;
                        end else begin
                            buf_nx   = shifted_s;
                            n_nx     = n_inc_s;
                            state_nx = ST_PROGRAM;
                        end
                    end else if (!door_closed) begin
                        tmr_load_s = 1'b1;
                    end else begin
                        tmr_run_s = 1'b1;
                        if (tmr_zero_s || (tmr_tick_s && (tmr_sec_s == 8'd1))) begin
                            state_nx = ST_IDLE;
                        end else begin
                            state_nx = ST_OPEN;
                        end
                    end
                end
                ST_PROGRAM: begin
                    if (clear || !prog_en) begin
                        buf_nx     = '0;
                        n_nx       = 4'd0;
                        state_nx   = ST_OPEN;
                        tmr_load_s = 1'b1;
                    end else if (enter) begin
                        if (last_dig_s) begin
                            code_nx      = shifted_s;
                            prog_done_nx = 1'b1;
                            buf_nx       = '0;
                            n_nx         = 4'd0;
                            state_nx     = ST_OPEN;
                            tmr_load_s   = 1'b1;
                        end else begin
                            buf_nx = shifted_s;
                            n_nx   = n_inc_s;
                        end
                    end else begin
                        state_nx = state_r;
                    end
                end
                ST_LOCKOUT: begin
                    tmr_run_s = 1'b1;
                    if (tmr_zero_s || (tmr_tick_s && (tmr_sec_s == 8'd1))) begin
                        state_nx = ST_IDLE;
                        tries_nx = TRIES_MAX;
                    end else begin
                        state_nx = ST_LOCKOUT;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                    buf_nx   = '0;
                    n_nx     = 4'd0;
                end
            endcase
        end
    end

    // State, buffer, password and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            buf_r        <= '0;
            code_r       <= DEFAULT_CODE;
            n_r          <= 4'd0;
            tries_r      <= TRIES_MAX;
            unlock_r     <= 1'b0;
            locked_out_r <= 1'b0;
            err_r        <= 1'b0;
            prog_done_r  <= 1'b0;
        end else begin
            state_r      <= state_nx;
            buf_r        <= buf_nx;
            code_r       <= code_nx;
            n_r          <= n_nx;
            tries_r      <= tries_nx;
            unlock_r     <= lock_released(state_nx);
            locked_out_r <= (state_nx == ST_LOCKOUT);
            err_r        <= err_nx;
            prog_done_r  <= prog_done_nx;
        end
    end

    assign unlock     = unlock_r;
    assign locked_out = locked_out_r;
    assign err        = err_r;
    assign prog_done  = prog_done_r;
    assign tries_left = tries_r;
    assign n_digits   = n_r;
    assign sec_left   = tmr_sec_s;
    assign state      = state_r;

endmodule

// File: tb/tb_controle_acesso.sv
// Scoreboard bench for controle_acesso: expected output events are queued by
// the stimulus and matched by a monitor whenever the DUT outputs change.
module tb_controle_acesso;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ENTRY   = 3'd1;
    localparam logic [2:0] S_CHECK   = 3'd2;
    localparam logic [2:0] S_OPEN    = 3'd3;
    localparam logic [2:0] S_LOCKOUT = 3'd4;
    localparam logic [2:0] S_PROGRAM = 3'd5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] digit = 4'd0;
    logic       enter = 1'b0;
    logic       clear = 1'b0;
    logic       door_closed = 1'b1;
    logic       prog_en = 1'b0;
    logic       emerg = 1'b0;
    logic       unlock, locked_out, err, prog_done;
    logic [2:0] tries_left;
    logic [3:0] n_digits;
    logic [7:0] sec_left;
    logic [2:0] state;

    typedef struct {
        logic [2:0] st;
        logic [3:0] n;
        logic [2:0] tr;
        logic [7:0] sec;
        logic       ul;
        logic       lo;
        logic       er;
        logic       pd;
        int         gap;
    } ev_t;

    ev_t   exp_q[$];
    int    checks = 0;
    int    failures = 0;
    int    ev_idx = 0;
    int    since = 0;
    logic  mon_on = 1'b0;
    logic  first = 1'b1;
    logic [19:0] prev = 20'd0;
    logic [19:0] cur;
    ev_t   e;

    controle_acesso #(
        .DIGITS       (4),
        .DEFAULT_CODE (16'h1234),
        .MAX_TRIES    (3),
        .TICK_DIV     (10),
        .LOCK_SEC     (3),
        .RELOCK_SEC   (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .digit       (digit),
        .enter       (enter),
        .clear       (clear),
        .door_closed (door_closed),
        .prog_en     (prog_en),
        .emerg       (emerg),
        .unlock      (unlock),
        .locked_out  (locked_out),
        .err         (err),
        .prog_done   (prog_done),
        .tries_left  (tries_left),
        .n_digits    (n_digits),
        .sec_left    (sec_left),
        .state       (state)
    );

    always #5 clk = ~clk;

    // Monitor: an event is any change of the level outputs or a pulse
    always @(negedge clk) begin
        if (mon_on) begin
            since = since + 1;
            cur = {state, n_digits, tries_left, sec_left, unlock, locked_out};
            if (first || (cur != prev) || err || prog_done) begin
                checks = checks + 1;
                if (exp_q.size() == 0) begin
                    failures = failures + 1;
                    $display("FAIL ev%0d unexpected: st=%0d n=%0d tries=%0d sec=%0d unlock=%0b lo=%0b err=%0b pd=%0b, want no event",
                             ev_idx, state, n_digits, tries_left, sec_left, unlock, locked_out, err, prog_done);
                end else begin
                    e = exp_q.pop_front();
                    if (state !== e.st || n_digits !== e.n || tries_left !== e.tr || sec_left !== e.sec ||
                        unlock !== e.ul || locked_out !== e.lo || err !== e.er || prog_done !== e.pd ||
                        (e.gap >= 0 && since != e.gap)) begin
                        failures = failures + 1;
                        $display("FAIL ev%0d: got st=%0d n=%0d tries=%0d sec=%0d unlock=%0b lo=%0b err=%0b pd=%0b gap=%0d, want st=%0d n=%0d tries=%0d sec=%0d unlock=%0b lo=%0b err=%0b pd=%0b gap=%0d",
                                 ev_idx, state, n_digits, tries_left, sec_left, unlock, locked_out, err, prog_done, since,
                                 e.st, e.n, e.tr, e.sec, e.ul, e.lo, e.er, e.pd, e.gap);
                    end
                end
                ev_idx = ev_idx + 1;
                since = 0;
                first = 1'b0;
            end
            prev = cur;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic ex(input logic [2:0] st, input logic [3:0] n, input logic [2:0] tr, input logic [7:0] sec,
                      input logic ul, input logic lo, input logic er, input logic pd, input int gap);
        ev_t x;
        x.st = st; x.n = n; x.tr = tr; x.sec = sec;
        x.ul = ul; x.lo = lo; x.er = er; x.pd = pd; x.gap = gap;
        exp_q.push_back(x);
    endtask

    task automatic press(input logic [3:0] d);
        digit = d;
        enter = 1'b1;
        step();
        enter = 1'b0;
        step();
    endtask

    task automatic type_code(input logic [15:0] c);
        for (int i = 3; i >= 0; i--) press(c[i*4 +: 4]);
    endtask

    // Three ENTRY digits two cycles apart, then CHECK on the fourth
    task automatic exp_code(input logic [2:0] tr);
        ex(S_ENTRY, 4'd1, tr, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        ex(S_ENTRY, 4'd2, tr, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        ex(S_ENTRY, 4'd3, tr, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        ex(S_CHECK, 4'd4, tr, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    endtask

    task automatic exp_open_after_check();
        ex(S_OPEN, 4'd0, 3'd3, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    endtask

    task automatic exp_relock();
        ex(S_OPEN, 4'd0, 3'd3, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0, 10);
        ex(S_IDLE, 4'd0, 3'd3, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10);
    endtask

    task automatic wrong_code(input logic [2:0] tr);
        exp_code(tr);
        if (tr == 3'd1) begin
            ex(S_LOCKOUT, 4'd0, 3'd0, 8'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1);
        end else begin
            ex(S_IDLE, 4'd0, 3'(tr - 3'd1), 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        end
        type_code(16'h0000);
    endtask

    initial begin
        idle(3);
        ex(S_IDLE, 4'd0, 3'd3, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        reset = 1'b0;
        mon_on = 1'b1;
        idle(2);

        // Correct default code, then relock after two closed-door seconds
        exp_code(3'd3);
        exp_open_after_check();
        exp_relock();
        type_code(16'h1234);
        idle(25);

        // Three wrong codes, lockout with enters ignored, then recovery
        for (int t = 3; t >= 1; t--) wrong_code(3'(t));
        ex(S_LOCKOUT, 4'd0, 3'd0, 8'd2, 1'b0, 1'b1, 1'b0, 1'b0, 10);
        ex(S_LOCKOUT, 4'd0, 3'd0, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0, 10);
        ex(S_IDLE,    4'd0, 3'd3, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10);
        press(4'd1);
        press(4'd2);
        press(4'd3);
        idle(26);

        // Clear beats a simultaneous enter
        ex(S_ENTRY, 4'd1, 3'd3, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        ex(S_ENTRY, 4'd2, 3'd3, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        ex(S_IDLE,  4'd0, 3'd3, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        press(4'd1);
        press(4'd2);
        digit = 4'd3;
        enter = 1'b1;
        clear = 1'b1;
        step();
        enter = 1'b0;
        clear = 1'b0;
        idle(3);

        // Reprogram to 9876, old code now rejected, new code accepted
        exp_code(3'd3);
        exp_open_after_check();
        ex(S_PROGRAM, 4'd1, 3'd3, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        ex(S_PROGRAM, 4'd2, 3'd3, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0, 2);
        ex(S_PROGRAM, 4'd3, 3'd3, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0, 2);
        ex(S_OPEN,    4'd0, 3'd3, 8'd2, 1'b1, 1'b0, 1'b0, 1'b1, 2);
        exp_relock();
        type_code(16'h1234);
        prog_en = 1'b1;
        type_code(16'h9876);
        prog_en = 1'b0;
        idle(25);
        exp_code(3'd3);
        ex(S_IDLE, 4'd0, 3'd2, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        type_code(16'h1234);
        exp_code(3'd2);
        exp_open_after_check();
        exp_relock();
        type_code(16'h9876);
        idle(25);

        // Emergency key during lockout opens the next cycle
        for (int t = 3; t >= 1; t--) wrong_code(3'(t));
        ex(S_OPEN, 4'd0, 3'd3, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0, 6);
        exp_relock();
        idle(5);
        emerg = 1'b1;
        step();
        emerg = 1'b0;
        idle(25);

        // Door held open freezes relock; reset mid-PROGRAM restores default code
        exp_code(3'd3);
        exp_open_after_check();
        type_code(16'h9876);
        door_closed = 1'b0;
        idle(50);
        door_closed = 1'b1;
        prog_en = 1'b1;
        ex(S_PROGRAM, 4'd1, 3'd3, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        ex(S_PROGRAM, 4'd2, 3'd3, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0, 2);
        ex(S_IDLE,    4'd0, 3'd3, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        press(4'd5);
        press(4'd5);
        reset = 1'b1;
        prog_en = 1'b0;
        step();
        reset = 1'b0;
        idle(2);
        exp_code(3'd3);
        exp_open_after_check();
        exp_relock();
        type_code(16'h1234);
        idle(25);

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks = checks + 1;
            failures = failures + 1;
            $display("FAIL missing event: got none, want st=%0d n=%0d tries=%0d sec=%0d", e.st, e.n, e.tr, e.sec);
        end
        idle(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
